// File: rtl/video_vblank_write_sched.sv
// Write scheduler between the FPro video bus and the video decoder: deferred-slot
// register writes are queued and replayed in a burst after frame_start.
module video_vblank_write_sched #(
    parameter int         AW_Q       = 4,
    parameter logic [7:0] DEFER_MASK = 8'hFE
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_cs,
    input  logic            s_wr,
    input  logic [20:0]     s_addr,
    input  logic [31:0]     s_wr_data,
    input  logic            frame_start,
    input  logic            defer_en,
    input  logic            clr_flags,
    output logic            m_cs,
    output logic            m_wr,
    output logic [20:0]     m_addr,
    output logic [31:0]     m_wr_data,
    output logic [AW_Q:0]   q_count,
    output logic            ovf,
    output logic            late
);
    localparam int DEPTH = 2 ** AW_Q;
    localparam int QW    = AW_Q + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [QW-1:0]   q_count_q, q_count_d;
    logic [AW_Q-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW_Q-1:0] wr_ptr_q, wr_ptr_d;
    logic            ovf_q, ovf_d;
    logic            late_q, late_d;
    logic            m_cs_q, m_cs_d;
    logic            m_wr_q, m_wr_d;
    logic [20:0]     m_addr_q, m_addr_d;
    logic [31:0]     m_wr_data_q, m_wr_data_d;

    logic [52:0]     queue_mem [DEPTH];
    logic [52:0]     head;

    logic [2:0]      slot;
    logic            host_wr;
    logic            deferred;
    logic            pass;
    logic            pop;
    logic            full;
    logic            enq_ok;
    logic            drop;

    assign slot    = s_addr[16:14];
    assign host_wr = s_cs & s_wr;
    // Once anything is queued, later deferred-slot writes must queue behind it to keep order.
    assign deferred = host_wr & ~s_addr[20] & DEFER_MASK[slot]
                    & (defer_en | (q_count_q != '0));
    assign pass     = s_cs & ~deferred;
    assign pop      = (state_q == DRAIN) & ~pass & (drain_cnt_q != '0);
    assign full     = (q_count_q == QW'(DEPTH));
    assign enq_ok   = deferred & (~full | pop);
    assign drop     = deferred & full & ~pop;
    assign head     = queue_mem[rd_ptr_q];

    // Storage has no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            queue_mem[wr_ptr_q] <= {s_addr, s_wr_data};
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        q_count_d   = q_count_q;
        ovf_d       = ovf_q;
        late_d      = late_q;
        m_cs_d      = 1'b0;
        m_wr_d      = 1'b0;
        m_addr_d    = m_addr_q;
        m_wr_data_d = m_wr_data_q;

        case (state_q)
            IDLE: begin
                if (frame_start && (q_count_q != '0)) begin
                    drain_cnt_d = q_count_q;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (pop) begin
                    drain_cnt_d = drain_cnt_q - QW'(1);
                    if (drain_cnt_q == QW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enq_ok) begin
            wr_ptr_d = wr_ptr_q + AW_Q'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW_Q'(1);
        end
        case ({enq_ok, pop})
            2'b10:   q_count_d = q_count_q + QW'(1);
            2'b01:   q_count_d = q_count_q - QW'(1);
            default: q_count_d = q_count_q;
        endcase

        if (pass) begin
            m_cs_d      = 1'b1;
            m_wr_d      = s_wr;
            m_addr_d    = s_addr;
            m_wr_data_d = s_wr_data;
        end else if (pop) begin
            m_cs_d      = 1'b1;
            m_wr_d      = 1'b1;
            m_addr_d    = head[52:32];
            m_wr_data_d = head[31:0];
        end

        if (clr_flags) begin
            ovf_d  = 1'b0;
            late_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (frame_start && (state_q == DRAIN)) begin
            late_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            q_count_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            late_q      <= 1'b0;
            m_cs_q      <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            q_count_q   <= q_count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            ovf_q       <= ovf_d;
            late_q      <= late_d;
            m_cs_q      <= m_cs_d;
            m_wr_q      <= m_wr_d;
            m_addr_q    <= m_addr_d;
            m_wr_data_q <= m_wr_data_d;
        end
    end

    assign m_cs      = m_cs_q;
    assign m_wr      = m_wr_q;
    assign m_addr    = m_addr_q;
    assign m_wr_data = m_wr_data_q;
    assign q_count   = q_count_q;
    assign ovf       = ovf_q;
    assign late      = late_q;

endmodule
